// File: rtl/c_demux_bus_reg.sv
// Registered one-to-many bus demultiplexer with a one-entry valid/ready holding register per lane.
// Optional sticky out-of-range select flag on ERR is enabled by defining C_DEMUX_ERR_EN.
module c_demux_bus_reg #(
  parameter int C_WIDTH     = 2,
  parameter int C_OUTPUTS   = 4,
  parameter int C_SEL_WIDTH = 2,
  parameter int C_HAS_CE    = 0,
  parameter     C_SINIT_VAL = "0"
) (
  input  logic                           CLK,
  input  logic                           ACLR_N,
  input  logic                           CE,
  input  logic                           SCLR,
  input  logic [C_WIDTH-1:0]             D,
  input  logic [C_SEL_WIDTH-1:0]         S,
  input  logic                           DV,
  output logic                           D_RDY,
  output logic [C_OUTPUTS*C_WIDTH-1:0]   Q,
  output logic [C_OUTPUTS-1:0]           QV,
  input  logic [C_OUTPUTS-1:0]           QR,
  output logic                           ERR
);

  localparam int SINIT_BITS = $bits(C_SINIT_VAL);
  localparam int NSEL       = 2 ** C_SEL_WIDTH;

  // C_SINIT_VAL is an ASCII string of '0'/'1'; its rightmost character is bit 0.
  function automatic logic [C_WIDTH-1:0] sinit_word();
    logic [SINIT_BITS-1:0] str;
    logic [C_WIDTH-1:0]    v;
    str = C_SINIT_VAL;
    v   = '0;
    for (int i = 0; i < C_WIDTH; i++) begin
      if (i < SINIT_BITS / 8) begin
        if (str[8*i +: 8] == 8'h31) v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  localparam logic [C_WIDTH-1:0] SINIT = sinit_word();

  logic                         en;
  logic                         rdy;
  logic [NSEL-1:0]              free_ext;
  logic [C_OUTPUTS-1:0]         sel_hot;
  logic [C_OUTPUTS-1:0]         acc;
  logic [C_OUTPUTS*C_WIDTH-1:0] q_q;
  logic [C_OUTPUTS-1:0]         qv_q;

  assign en = (C_HAS_CE != 0) ? CE : 1'b1;

  // Selects beyond the last lane read as always free, so out-of-range words are taken and dropped.
  always_comb begin
    free_ext = '1;
    sel_hot  = '0;
    for (int i = 0; i < C_OUTPUTS; i++) begin
      free_ext[i] = ~qv_q[i] | QR[i];
      sel_hot[i]  = (S == C_SEL_WIDTH'(i));
    end
  end

  assign rdy   = ACLR_N & en & ~SCLR & free_ext[S];
  assign acc   = {C_OUTPUTS{DV & rdy}} & sel_hot;
  assign D_RDY = rdy;
  assign Q     = q_q;
  assign QV    = qv_q;

  // NOTE: the lane data registers are reset as well, because Q must show C_SINIT_VAL during reset.
  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      qv_q <= '0;
      q_q  <= {C_OUTPUTS{SINIT}};
    end else if (SCLR) begin
      qv_q <= '0;
      q_q  <= {C_OUTPUTS{SINIT}};
    end else if (en) begin
      for (int i = 0; i < C_OUTPUTS; i++) begin
        // NOTE: non-blocking writes keep every lane reading pre-edge state regardless of loop order.
        if (acc[i]) begin
          q_q[i*C_WIDTH +: C_WIDTH] <= D;
          qv_q[i]                   <= 1'b1;
        end else if (QR[i]) begin
          qv_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef C_DEMUX_ERR_EN
  logic [NSEL-1:0] oor_ext;
  logic            err_q;

  always_comb begin
    oor_ext = '1;
    for (int i = 0; i < C_OUTPUTS; i++) oor_ext[i] = 1'b0;
  end

  // OR-ing rather than an if keeps an unknown select visible as X on ERR.
  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      err_q <= 1'b0;
    end else if (SCLR) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (en & DV & oor_ext[S]);
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_c_demux_bus_reg.sv
// Directed self-checking bench for c_demux_bus_reg: a 4-lane CE-gated instance
// and a 3-lane instance (non-zero init value, CE ignored) for out-of-range selects.
module tb_c_demux_bus_reg;

`ifdef C_DEMUX_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ce_a, sclr_a, dv_a, d_rdy_a, err_a;
  logic [7:0]  d_a;
  logic [1:0]  s_a;
  logic [31:0] q_a;
  logic [3:0]  qv_a, qr_a;

  logic        ce_b, sclr_b, dv_b, d_rdy_b, err_b;
  logic [7:0]  d_b;
  logic [1:0]  s_b;
  logic [23:0] q_b;
  logic [2:0]  qv_b, qr_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  c_demux_bus_reg #(
    .C_WIDTH(8), .C_OUTPUTS(4), .C_SEL_WIDTH(2), .C_HAS_CE(1), .C_SINIT_VAL("0")
  ) dut_a (
    .CLK(clk), .ACLR_N(rst_n), .CE(ce_a), .SCLR(sclr_a), .D(d_a), .S(s_a), .DV(dv_a),
    .D_RDY(d_rdy_a), .Q(q_a), .QV(qv_a), .QR(qr_a), .ERR(err_a)
  );

  c_demux_bus_reg #(
    .C_WIDTH(8), .C_OUTPUTS(3), .C_SEL_WIDTH(2), .C_HAS_CE(0), .C_SINIT_VAL("00001111")
  ) dut_b (
    .CLK(clk), .ACLR_N(rst_n), .CE(ce_b), .SCLR(sclr_b), .D(d_b), .S(s_b), .DV(dv_b),
    .D_RDY(d_rdy_b), .Q(q_b), .QV(qv_b), .QR(qr_b), .ERR(err_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ce_a = 1'b1; sclr_a = 1'b0; dv_a = 1'b1; d_a = 8'h00; s_a = 2'd0; qr_a = 4'b1111;
    ce_b = 1'b0; sclr_b = 1'b0; dv_b = 1'b0; d_b = 8'h00; s_b = 2'd0; qr_b = 3'b111;
    #12;
    check("rst_qv_a", qv_a, 4'b0000);
    check("rst_q_a", q_a, 32'h0);
    check("rst_rdy_a", d_rdy_a, 1'b0);
    check("rst_q_b", q_b, 24'h0F0F0F);
    check("rst_err_b", err_b, 1'b0);
    dv_a = 1'b0;
    step();
    rst_n = 1'b1;

    // Out-of-range select on the 3-lane instance; CE is low but ignored there.
    s_b = 2'd3; d_b = 8'hAA; dv_b = 1'b1;
    #1 check("b_oor_rdy", d_rdy_b, 1'b1);
    step();
    dv_b = 1'b0;
    check("b_oor_qv", qv_b, 3'b000);
    check("b_oor_q", q_b, 24'h0F0F0F);
    check("b_err_set", err_b, ERR_EXP);
    step();
    check("b_err_sticky", err_b, ERR_EXP);
    s_b = 2'd2; d_b = 8'hC3; dv_b = 1'b1; qr_b = 3'b000;
    step();
    dv_b = 1'b0;
    check("b_lane2_qv", qv_b, 3'b100);
    check("b_lane2_q", q_b, 24'hC30F0F);
    sclr_b = 1'b1;
    #1 check("b_sclr_rdy", d_rdy_b, 1'b0);
    step();
    sclr_b = 1'b0;
    check("b_sclr_qv", qv_b, 3'b000);
    check("b_sclr_q", q_b, 24'h0F0F0F);
    check("b_sclr_err", err_b, 1'b0);

    // Basic steering, all consumers ready.
    s_a = 2'd2; d_a = 8'hA5; dv_a = 1'b1;
    #1 check("steer_rdy", d_rdy_a, 1'b1);
    step();
    check("steer1_qv", qv_a, 4'b0100);
    check("steer1_lane2", q_a[23:16], 8'hA5);
    s_a = 2'd0; d_a = 8'h3C;
    step();
    dv_a = 1'b0;
    check("steer2_qv", qv_a, 4'b0001);
    check("steer2_q", q_a, 32'h00A5003C);
    step();
    check("drain_qv", qv_a, 4'b0000);
    check("drain_keeps_q", q_a, 32'h00A5003C);

    // Backpressure on lane 1, then drain and accept on the same edge.
    qr_a = 4'b1101; s_a = 2'd1; d_a = 8'h11; dv_a = 1'b1;
    #1 check("bp_rdy1", d_rdy_a, 1'b1);
    step();
    check("bp_qv1", qv_a, 4'b0010);
    check("bp_lane1_first", q_a[15:8], 8'h11);
    d_a = 8'h22;
    #1 check("bp_rdy_stall", d_rdy_a, 1'b0);
    step();
    check("bp_lane1_held", q_a[15:8], 8'h11);
    qr_a = 4'b1111;
    #1 check("bp_rdy_drain", d_rdy_a, 1'b1);
    step();
    check("bp_qv_swap", qv_a, 4'b0010);
    check("bp_lane1_second", q_a[15:8], 8'h22);

    // Lane 3 stalled does not block lane 0.
    qr_a = 4'b0111; s_a = 2'd3; d_a = 8'h99;
    step();
    check("ind_qv3", qv_a, 4'b1000);
    s_a = 2'd0; d_a = 8'h7E;
    #1 check("ind_rdy", d_rdy_a, 1'b1);
    step();
    check("ind_qv", qv_a, 4'b1001);
    check("ind_q", q_a, 32'h99A5227E);

    // CE low: no accept, no drain, D_RDY low.
    ce_a = 1'b0; s_a = 2'd1; d_a = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #1 check("ce_rdy", d_rdy_a, 1'b0);
      step();
      check("ce_qv", qv_a, 4'b1001);
      check("ce_q", q_a, 32'h99A5227E);
    end
    ce_a = 1'b1;
    #1 check("ce_on_rdy", d_rdy_a, 1'b1);
    step();
    dv_a = 1'b0;
    check("ce_on_qv", qv_a, 4'b1010);
    check("ce_on_q", q_a, 32'h99A5557E);

    // SCLR overrides CE.
    ce_a = 1'b0; sclr_a = 1'b1;
    step();
    sclr_a = 1'b0; ce_a = 1'b1;
    check("sclr_qv_a", qv_a, 4'b0000);
    check("sclr_q_a", q_a, 32'h0);

    // Fill lanes 0, 1, 3 with consumers stalled, then reset mid-stream.
    qr_a = 4'b0000; dv_a = 1'b1;
    s_a = 2'd0; d_a = 8'h01; step();
    s_a = 2'd1; d_a = 8'h02; step();
    s_a = 2'd3; d_a = 8'h04; step();
    s_a = 2'd2; d_a = 8'h08;
    check("fill_qv", qv_a, 4'b1011);
    check("fill_q", q_a, 32'h04000201);
    #2 rst_n = 1'b0;
    #1;
    check("arst_qv_a", qv_a, 4'b0000);
    check("arst_q_a", q_a, 32'h0);
    check("arst_rdy_a", d_rdy_a, 1'b0);
    check("arst_q_b", q_b, 24'h0F0F0F);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/c_demux_bus_reg.md
# c_demux_bus_reg

Registered one-to-many bus demultiplexer: the inverse of the LUT-based bus multiplexer. It steers one C_WIDTH input word to one of C_OUTPUTS output lanes, chosen by the binary select S. Each lane has a one-entry holding register with a valid/ready handshake, so a stalled consumer does not block traffic to the other lanes. It sits between a shared producer bus and per-channel consumers.

## Interface
- C_WIDTH, 2: data width in bits, 1..256
- C_OUTPUTS, 4: number of output lanes, 2..32
- C_SEL_WIDTH, 2: select width; must satisfy 2^C_SEL_WIDTH >= C_OUTPUTS
- C_HAS_CE, 0: 1 = CE gates all state updates; 0 = CE is ignored and treated as 1
- C_SINIT_VAL, "0": binary string loaded into every lane data register on reset and on SCLR
- CLK  in  1  rising-edge clock, single clock domain
- ACLR_N  in  1  asynchronous, active-low reset
- CE  in  1  clock enable (see C_HAS_CE)
- SCLR  in  1  synchronous clear; overrides CE
- D  in  C_WIDTH  input word
- S  in  C_SEL_WIDTH  lane select, binary; lane 0 = S==0
- DV  in  1  input valid
- D_RDY  out  1  input ready; a word transfers when DV & D_RDY
- Q  out  C_OUTPUTS*C_WIDTH  lane data; lane i occupies bits [i*C_WIDTH +: C_WIDTH]
- QV  out  C_OUTPUTS  per-lane valid
- QR  in  C_OUTPUTS  per-lane ready; lane i drains when QV[i] & QR[i]
- ERR  out  1  sticky out-of-range select flag (only with C_DEMUX_ERR_EN)

## Operation
- Each lane holds one data register and one valid bit.
- The effective enable en is CE when C_HAS_CE=1, otherwise 1.
- Lane i is free when QV[i]=0, or when QV[i]=1 and QR[i]=1 (it is draining in the same cycle).
- D_RDY is combinational: en & ~SCLR & (S >= C_OUTPUTS, or lane S is free).
- An out-of-range S (S >= C_OUTPUTS) is always ready and the word is discarded.
- Accept into lane i at a clock edge, when en & DV & D_RDY & S==i:
  - lane i data <= D
  - QV[i] <= 1
- Drain of lane i with no accept into it: QV[i] <= 0. The data register keeps its value, and Q is not zeroed.
- Simultaneous drain and accept on the same lane: the new word replaces the old one and QV stays 1. This gives one word per cycle of throughput per lane.
- Lanes not addressed by S are unaffected, apart from their own drains.
- en=0: nothing changes and D_RDY=0. Drains are also held off, so a consumer must not count a transfer while CE=0.
- SCLR=1 (overrides CE), at the edge:
  - all QV <= 0
  - all data <= C_SINIT_VAL
  - no accept happens
- Any X or Z bit on S while DV=1 and en=1: D_RDY=X, no lane updates, and an X state is driven on ERR when it is enabled.

## Timing
- Latency is 1 cycle: a word accepted at edge t appears on Q/QV immediately after edge t.
- D_RDY has a combinational path from QR and S. This is the only combinational input-to-output path.
- ACLR_N low, asynchronously:
  - QV = 0
  - every lane of Q = C_SINIT_VAL
  - ERR = 0
  - D_RDY = 0 while reset is held
- Reset mid-transfer: a word that is in flight is lost. No partial state remains.
- Release of ACLR_N is assumed synchronous to CLK. The first accept can happen at the first edge after release.

## Configuration
- C_DEMUX_ERR_EN defined:
  - ERR is set at the edge where en & DV & S >= C_OUTPUTS.
  - ERR is cleared only by ACLR_N or SCLR.
- C_DEMUX_ERR_EN undefined:
  - the ERR port is still present and tied to 0
  - out-of-range words are silently dropped
  - no flag logic is synthesized

## Test plan
- Basic steering: C_WIDTH=8, C_OUTPUTS=4, all QR=1. Send D=8'hA5 with S=2, then D=8'h3C with S=0 on the next cycle. Required: QV=4'b0100 with lane2=A5, then QV=4'b0001 with lane0=3C, and lane2 still reads A5.
- Backpressure: QR[1]=0, send 8'h11 then 8'h22 to S=1. Required: the first word is accepted and D_RDY=0 while the second is pending. Raising QR[1] for one cycle gives drain plus accept on that edge, after which lane1=22 and QV[1]=1.
- Independence: lane 3 is stalled with QR[3]=0 and QV[3]=1. Send 8'h7E to S=0. Required: D_RDY=1, lane0 receives 7E, and lane3 is unchanged.
- Out-of-range select: C_OUTPUTS=3, send DV=1 with S=3. Required: D_RDY=1, QV unchanged, and ERR=1 from the next cycle (0 when the macro is undefined). A following SCLR returns ERR to 0.
- CE gating (C_HAS_CE=1): CE=0 with DV=1 and S=1. Required: D_RDY=0 and no state change for 5 cycles. Setting CE=1 gives an accept on the next edge.
- Reset: drop ACLR_N mid-stream with QV=4'b1011. Required: QV=0 and Q equals C_SINIT_VAL on every lane, with no wait for a clock edge.
